// File: rtl/matmul_job_arbiter_if.sv
// Job/response/engine bundle for matmul_job_arbiter; the slave modport is the arbiter,
// the master modport is the client plus engine wrapper that surround it.
interface matmul_job_arbiter_if #(
  parameter int W = 32,
  parameter int N = 3
);
  localparam int MW = W * N * N;

  logic [1:0]      i_valid;
  logic [1:0]      i_mode;
  logic [2*MW-1:0] i_A;
  logic [2*MW-1:0] i_B;
  logic [1:0]      o_ready;
  logic [1:0]      o_rvalid;
  logic [1:0]      i_rready;
  logic [MW-1:0]   o_C;
  logic            o_rid;
  logic            o_busy;
  logic            o_eng_rst;
  logic            o_eng_en;
  logic            o_eng_mode;
  logic [MW-1:0]   o_eng_A;
  logic [MW-1:0]   o_eng_B;
  logic [MW-1:0]   i_eng_C;

  modport slave (
    input  i_valid, i_mode, i_A, i_B, i_rready, i_eng_C,
    output o_ready, o_rvalid, o_C, o_rid, o_busy,
           o_eng_rst, o_eng_en, o_eng_mode, o_eng_A, o_eng_B
  );

  modport master (
    output i_valid, i_mode, i_A, i_B, i_rready, i_eng_C,
    input  o_ready, o_rvalid, o_C, o_rid, o_busy,
           o_eng_rst, o_eng_en, o_eng_mode, o_eng_A, o_eng_B
  );
endinterface

// File: rtl/matmul_job_arbiter.sv
// Round-robin share of one systolic matmul engine between two requesters; accept-to-result LAT+2 cycles.
// Backpressure: a result waits in RESP until its owner's i_rready; no new job is granted meanwhile.
module matmul_job_arbiter #(
  parameter int W   = 32,
  parameter int N   = 3,
  parameter int LAT = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  matmul_job_arbiter_if.slave   bus
);
  localparam int MW = W * N * N;
  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;

  typedef struct packed {
    logic          mode;
    logic [MW-1:0] a;
    logic [MW-1:0] b;
  } job_t;

  state_t        state_q, state_d;
  logic          ptr_q;
  logic          id_q;
  logic [CW-1:0] cnt_q;
  job_t          job_q;
  job_t          job_in;
  logic [MW-1:0] c_q;

  logic win_vld;
  logic win;
  logic accept;
  logic run_last;

  // The pointer side wins ties; the other side only wins when the pointer side is idle.
  always_comb begin
    win_vld = 1'b0;
    win     = ptr_q;
    if (bus.i_valid[ptr_q]) begin
      win_vld = 1'b1;
      win     = ptr_q;
    end else if (bus.i_valid[~ptr_q]) begin
      win_vld = 1'b1;
      win     = ~ptr_q;
    end
  end

  always_comb begin
    job_in = '0;
    if (win) begin
      job_in.mode = bus.i_mode[1];
      job_in.a    = bus.i_A[2*MW-1:MW];
      job_in.b    = bus.i_B[2*MW-1:MW];
    end else begin
      job_in.mode = bus.i_mode[0];
      job_in.a    = bus.i_A[MW-1:0];
      job_in.b    = bus.i_B[MW-1:0];
    end
  end

  assign accept   = (state_q == IDLE) && win_vld && !i_rst;
  assign run_last = (state_q == RUN) && (cnt_q == CW'(LAT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CLR;
      CLR:     state_d = RUN;
      RUN:     if (run_last) state_d = RESP;
      RESP:    if (bus.i_rready[id_q]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= 1'b0;
      id_q  <= 1'b0;
      cnt_q <= '0;
      job_q <= '0;
      c_q   <= '0;
    end else begin
      if (accept) begin
        job_q <= job_in;
        id_q  <= win;
        ptr_q <= ~win;
      end
      // Last RUN cycle bumps cnt_q to LAT, which still fits CW bits.
      if (state_q == CLR)      cnt_q <= '0;
      else if (state_q == RUN) cnt_q <= cnt_q + CW'(1);
      if (run_last) c_q <= bus.i_eng_C;
    end
  end

  assign bus.o_ready    = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign bus.o_rvalid   = (state_q == RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.o_rid      = id_q;
  assign bus.o_C        = c_q;
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_eng_rst  = i_rst | (state_q == CLR);
  assign bus.o_eng_en   = (state_q == RUN);
  assign bus.o_eng_mode = job_q.mode;
  assign bus.o_eng_A    = job_q.a;
  assign bus.o_eng_B    = job_q.b;
endmodule

// File: tb/tb_matmul_job_arbiter.sv
// Bench for matmul_job_arbiter: directed jobs against a behavioural LAT-cycle engine,
// results checked by a scoreboard monitor that pops on every response handshake.
module tb_matmul_job_arbiter;
  localparam int W   = 32;
  localparam int N   = 3;
  localparam int LAT = 7;
  localparam int MW  = W * N * N;

  typedef struct packed {
    logic          rid;
    logic [MW-1:0] c;
  } exp_t;

  logic i_clk;
  logic i_rst;
  int   checks   = 0;
  int   failures = 0;
  int   n_results = 0;
  int   en_cnt;
  exp_t sbq[$];

  matmul_job_arbiter_if #(.W(W), .N(N)) bus();

  matmul_job_arbiter #(.W(W), .N(N), .LAT(LAT)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [MW-1:0] mat_seq(input int base, input int step);
    logic [MW-1:0] m;
    m = '0;
    for (int k = 0; k < N*N; k++) m[k*W +: W] = W'(base + k*step);
    return m;
  endfunction

  function automatic logic [MW-1:0] ident(input int scale);
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[(i*N+i)*W +: W] = W'(scale);
    return m;
  endfunction

  // Engine: A*B (plus one per element in mode 1), valid only on the LAT-th enabled cycle.
  function automatic logic [MW-1:0] eng_model(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                              input logic m);
    logic [MW-1:0] c;
    logic [W-1:0]  s;
    c = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++) s = s + a[(i*N+k)*W +: W] * b[(k*N+j)*W +: W];
        c[(i*N+j)*W +: W] = s + W'(m);
      end
    end
    return c;
  endfunction

  always @(posedge i_clk) begin
    if (bus.o_eng_rst)     en_cnt <= 0;
    else if (bus.o_eng_en) en_cnt <= en_cnt + 1;
  end

  assign bus.i_eng_C = (bus.o_eng_en && en_cnt == LAT - 1)
                     ? eng_model(bus.o_eng_A, bus.o_eng_B, bus.o_eng_mode) : {MW{1'b1}};

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst && bus.o_rvalid != 2'b00 && bus.i_rready[bus.o_rid]) begin
      n_results++;
      if (sbq.size() == 0) begin
        check("unexpected_result", MW'(bus.o_rvalid), MW'(0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("result_rid", MW'(bus.o_rid), MW'(e.rid));
        check("result_rvalid_onehot", MW'(bus.o_rvalid), MW'(e.rid ? 2'b10 : 2'b01));
        check("result_C", bus.o_C, e.c);
      end
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ready(output int w);
    w = 0;
    #1;
    while (bus.o_ready == 2'b00 && w < 40) begin
      tick();
      #1;
      w++;
    end
  endtask

  // Called at the cycle whose closing edge accepts; returns cycles until o_rvalid.
  task automatic run_job(output int lat, output int ens, output int rst_at);
    lat    = 0;
    ens    = 0;
    rst_at = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.o_eng_rst && rst_at < 0) rst_at = k;
      if (bus.o_eng_en) ens++;
      if (bus.o_rvalid != 2'b00) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lat, ens, rst_at, bad;

    i_rst        = 1'b1;
    bus.i_valid  = 2'b11;
    bus.i_mode   = 2'b00;
    bus.i_A      = '0;
    bus.i_B      = '0;
    bus.i_rready = 2'b00;

    // Reset with both requesters asking.
    repeat (3) tick();
    #1;
    check("rst_ready",   MW'(bus.o_ready),   MW'(0));
    check("rst_rvalid",  MW'(bus.o_rvalid),  MW'(0));
    check("rst_busy",    MW'(bus.o_busy),    MW'(0));
    check("rst_eng_rst", MW'(bus.o_eng_rst), MW'(1));
    check("rst_eng_en",  MW'(bus.o_eng_en),  MW'(0));
    check("rst_C",       bus.o_C,            MW'(0));
    check("rst_eng_A",   bus.o_eng_A,        MW'(0));
    tick();
    i_rst = 1'b0;
    #1;
    check("ready_after_reset", MW'(bus.o_ready), MW'(2'b01));
    bus.i_valid = 2'b00;

    // Single job: identity * (1..9) from requester 0.
    tick();
    bus.i_valid  = 2'b01;
    bus.i_A      = {ident(1), ident(1)};
    bus.i_B      = {mat_seq(10, 1), mat_seq(1, 1)};
    bus.i_mode   = 2'b10;
    bus.i_rready = 2'b11;
    sbq.push_back('{rid: 1'b0, c: mat_seq(1, 1)});
    wait_ready(w);
    check("single_ready", MW'(bus.o_ready), MW'(2'b01));
    run_job(lat, ens, rst_at);
    check("single_eng_rst_at", MW'(rst_at), MW'(1));
    check("single_en_cycles",  MW'(ens),    MW'(LAT));
    check("single_latency",    MW'(lat),    MW'(LAT + 2));
    check("single_eng_A_held", bus.o_eng_A, ident(1));
    check("single_eng_mode",   MW'(bus.o_eng_mode), MW'(0));
    check("single_resp_en",    MW'(bus.o_eng_en),   MW'(0));
    bus.i_valid = 2'b00;
    tick();
    check("single_rvalid_drop", MW'(bus.o_rvalid), MW'(0));
    check("single_idle",        MW'(bus.o_busy),   MW'(0));

    // Back-to-back from requester 1 only; rready[0] wiggles but is not the owner.
    bus.i_valid = 2'b10;
    for (int j = 0; j < 3; j++) begin
      bus.i_rready = (j % 2 == 0) ? 2'b11 : 2'b10;
      sbq.push_back('{rid: 1'b1, c: mat_seq(11, 1)});
      wait_ready(w);
      check("tput_ready", MW'(bus.o_ready), MW'(2'b10));
      if (j > 0) check("tput_gap", MW'(w), MW'(0));
      run_job(lat, ens, rst_at);
      check("tput_latency", MW'(lat), MW'(LAT + 2));
      if (j == 2) bus.i_valid = 2'b00;
      tick();
    end

    // Contention: both valid, grants must alternate 0,1,0,1.
    bus.i_A      = {ident(1), ident(2)};
    bus.i_B      = {mat_seq(10, 1), mat_seq(1, 1)};
    bus.i_mode   = 2'b10;
    bus.i_rready = 2'b11;
    bus.i_valid  = 2'b11;
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 0) sbq.push_back('{rid: 1'b0, c: mat_seq(2, 2)});
      else            sbq.push_back('{rid: 1'b1, c: mat_seq(11, 1)});
      wait_ready(w);
      check("contend_grant", MW'(bus.o_ready), MW'((j % 2 == 1) ? 2'b10 : 2'b01));
      if (j > 0) check("contend_gap", MW'(w), MW'(0));
      run_job(lat, ens, rst_at);
      check("contend_latency", MW'(lat), MW'(LAT + 2));
      if (j == 3) bus.i_valid = 2'b00;
      tick();
    end

    // Backpressure: requester 0 result held 20 cycles, non-owner rready toggles.
    bus.i_valid  = 2'b01;
    bus.i_rready = 2'b00;
    sbq.push_back('{rid: 1'b0, c: mat_seq(2, 2)});
    wait_ready(w);
    check("bp_ready", MW'(bus.o_ready), MW'(2'b01));
    run_job(lat, ens, rst_at);
    check("bp_latency", MW'(lat), MW'(LAT + 2));
    bus.i_valid = 2'b11;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      bus.i_rready = {k[0], 1'b0};
      #1;
      if (bus.o_rvalid !== 2'b01 || bus.o_rid !== 1'b0 || bus.o_C !== mat_seq(2, 2) ||
          bus.o_ready !== 2'b00 || bus.o_eng_en !== 1'b0) bad++;
      tick();
    end
    check("bp_stable_cycles_bad", MW'(bad), MW'(0));
    bus.i_rready = 2'b01;
    bus.i_valid  = 2'b00;
    tick();
    check("bp_rvalid_after_accept", MW'(bus.o_rvalid), MW'(0));

    // Reset in the third RUN cycle of a requester-1 job: no result may appear.
    bus.i_rready = 2'b11;
    bus.i_valid  = 2'b10;
    wait_ready(w);
    check("midrst_ready", MW'(bus.o_ready), MW'(2'b10));
    tick();
    bus.i_valid = 2'b00;
    tick();
    tick();
    tick();
    check("midrst_in_run", MW'(bus.o_eng_en), MW'(1));
    i_rst = 1'b1;
    tick();
    check("midrst_busy",    MW'(bus.o_busy),    MW'(0));
    check("midrst_rvalid",  MW'(bus.o_rvalid),  MW'(0));
    check("midrst_eng_rst", MW'(bus.o_eng_rst), MW'(1));
    i_rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.o_rvalid != 2'b00) bad++;
    end
    check("midrst_no_rvalid", MW'(bad), MW'(0));

    // Fresh job after reset: pointer is back at 0.
    bus.i_valid = 2'b11;
    sbq.push_back('{rid: 1'b0, c: mat_seq(2, 2)});
    wait_ready(w);
    check("fresh_ready", MW'(bus.o_ready), MW'(2'b01));
    run_job(lat, ens, rst_at);
    check("fresh_latency", MW'(lat), MW'(LAT + 2));
    bus.i_valid = 2'b00;
    tick();
    tick();

    check("sb_drained",  MW'(sbq.size()), MW'(0));
    check("result_count", MW'(n_results), MW'(10));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/matmul_job_arbiter.md
# matmul_job_arbiter

Shares one N×N systolic matrix-multiply engine between two requesters. Accepts whole-matrix jobs over a valid/ready handshake and arbitrates round-robin. For each job it clears the engine, enables it for a fixed compute window, captures the result, and returns it on a shared response bus tagged with the requester ID. It sits between client logic and the engine's sequencing wrapper, which owns operand skewing and consumes en/mode/A/B.

## Interface
- W, 32, element width in bits
- N, 3, matrix dimension; matrices are packed flat, W*N*N bits, element k at bits [k*W +: W]
- LAT, 7, engine cycles from first enabled cycle until C is valid; LAT ≥ 1

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_valid  in  2  job request per requester (bit k = requester k)
- i_mode  in  2  engine mode bit per requester
- i_A  in  2*W*N*N  operand A; requester k at [k*W*N*N +: W*N*N]
- i_B  in  2*W*N*N  operand B; same packing as i_A
- o_ready  out  2  job accept; one-hot or zero
- o_rvalid  out  2  result valid for requester k; one-hot or zero
- i_rready  in  2  result accept per requester
- o_C  out  W*N*N  result matrix
- o_rid  out  1  requester ID of the current result
- o_busy  out  1  high in every state except IDLE
- o_eng_rst  out  1  engine clear
- o_eng_en  out  1  engine enable
- o_eng_mode  out  1  latched job mode
- o_eng_A  out  W*N*N  latched operand A
- o_eng_B  out  W*N*N  latched operand B
- i_eng_C  in  W*N*N  engine result

## Operation
- FSM states: IDLE → CLR → RUN → RESP → IDLE.
- **IDLE**
  - Winner = requester at pointer `ptr` if its i_valid is high; otherwise the other requester if its i_valid is high; otherwise none.
  - o_ready[winner] = 1; all other o_ready bits are 0.
  - On an edge with i_valid[k] & o_ready[k]: latch i_A, i_B, i_mode slices into the engine operand registers; latch id = k; set ptr = ~k; go to CLR.
- **CLR** (1 cycle): o_eng_rst = 1, o_eng_en = 0; load counter = 0; go to RUN.
- **RUN** (exactly LAT cycles): o_eng_en = 1; counter increments each cycle.
  - On the edge ending the cycle where counter == LAT-1: register i_eng_C into the result register; go to RESP.
- **RESP**: o_rvalid[id] = 1, o_rid = id, o_C = result register; o_eng_en = 0.
  - On an edge with i_rready[id] = 1: go to IDLE.
  - i_rready bit of the non-owner is ignored.
- o_eng_A, o_eng_B and o_eng_mode hold their latched values from accept until the next accept. They are stable throughout CLR and RUN.
- o_eng_rst = i_rst | (state == CLR).
- Counter width is clog2(LAT+1); it never wraps within a job.
- No new request is accepted outside IDLE. A requester may drop i_valid before it is granted without side effects.

## Timing
- Reset values: state = IDLE, ptr = 0, o_ready = 0, o_rvalid = 0, o_rid = 0, o_C = 0, o_busy = 0, o_eng_en = 0, o_eng_mode = 0, o_eng_A = 0, o_eng_B = 0, o_eng_rst = 1 while i_rst is high.
- Accept edge at cycle T:
  - CLR at T+1.
  - RUN during T+2 … T+1+LAT.
  - o_rvalid high from T+2+LAT.
  - Accept-to-result latency is LAT+2 cycles.
- With i_rready held high, the response handshake takes one cycle and IDLE is re-entered at T+3+LAT. The minimum job period is therefore LAT+3 cycles (10 at LAT=7).
- o_ready and the winner are combinational from state, ptr and i_valid. All other outputs are registered or decoded from state.
- Reset asserted in any state: the next cycle is IDLE with reset values; the in-flight job and its result are discarded and no o_rvalid is issued.
- Simultaneous i_valid = 2'b11 in IDLE: ptr decides. Grants alternate 0, 1, 0, 1 … under continuous contention.

## Test plan
- **Reset:** hold i_rst 3 cycles with i_valid = 2'b11 → o_ready = 00, o_rvalid = 00, o_busy = 0, o_eng_rst = 1, o_C = 0. After release, o_ready = 01.
- **Single job (LAT=7, behavioral engine model computing A·B):** requester 0 submits A = identity, B = 1..9.
  - Required: o_ready = 01 at accept; o_eng_rst pulse 1 cycle later; o_eng_en high for exactly 7 cycles; o_rvalid = 01 with o_rid = 0 and o_C = 1..9 at accept+9.
- **Contention:** i_valid = 11 continuously for 4 jobs → grant order 0, 1, 0, 1. Each result's o_rid matches the grant order, and the operands match the submitting requester.
- **Backpressure:** i_rready = 00 for 20 cycles during RESP → o_C, o_rid and o_rvalid stay stable; o_ready = 00; o_eng_en = 0. After i_rready[id] = 1 for one edge, o_rvalid = 00 the next cycle.
- **Reset mid-RUN:** assert i_rst at RUN cycle 3 → IDLE next cycle, o_rvalid never asserts for that job. A fresh job afterwards completes normally with latency 9.
- **Back-to-back throughput:** requester 1 only, i_valid and i_rready held high → accepts every 10 cycles and o_rvalid = 10 once per job. i_rready[0] pulses from the bench are ignored.
